// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command-side initiator for the 8-bit ALU pipeline. It accepts register-based
// ALU commands over a valid/ready handshake and reads operands from a small
// internal register file. It drives the ALU inputs, waits ALU_LATENCY cycles,
// then writes the result back and latches the returned flags.
//
// Optional feature macro: ALU_CMP_NOWB_EN
//   defined   : compare opcodes 5'b00110..5'b01011 update flags only (no rd write)
//   undefined : every opcode, compares included, writes its result to rd
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_op, cmd_rd, cmd_rs1,
//   cmd_rs2, cmd_use_carry    command fields
//   ld_en, ld_addr, ld_data   direct register load (honoured in IDLE only)
//   rd_addr / rd_data         combinational debug read port
//   alu_a, alu_b,
//   alu_carry_in, alu_ctrl    registered ALU inputs, held from ISSUE through WB
//   alu_result, alu_flag_*    ALU result and flags, sampled in WB
//   done                      one-cycle pulse in the writeback cycle
//   flags                     stored {C,Z,V,N}
module alu_op_sequencer #(
  parameter int NREGS       = 4,
  parameter int REG_AW      = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic              cmd_use_carry,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic              alu_carry_in,
  output logic [4:0]        alu_ctrl,
  input  logic [7:0]        alu_result,
  input  logic              alu_flag_carry,
  input  logic              alu_flag_zero,
  input  logic              alu_flag_overflow,
  input  logic              alu_flag_negative,
  output logic              done,
  output logic [3:0]        flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  // Number of WAIT cycles between ISSUE and WB.
  localparam logic [2:0] LAT_M1 = 3'(ALU_LATENCY - 1);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [7:0]          regs_q [NREGS];
  logic [7:0]          regs_d [NREGS];
  logic [3:0]          flags_q, flags_d;
  logic [7:0]          alu_a_q, alu_a_d;
  logic [7:0]          alu_b_q, alu_b_d;
  logic                alu_carry_in_q, alu_carry_in_d;
  logic [4:0]          alu_ctrl_q, alu_ctrl_d;
  logic                wb_write_s;

  // Compare opcodes occupy the contiguous range 00110..01011.
  function automatic logic is_cmp_op(input logic [4:0] op);
    return (op >= 5'b00110) && (op <= 5'b01011);
  endfunction

  // Decide whether the WB cycle writes the destination register.
`ifdef ALU_CMP_NOWB_EN
  assign wb_write_s = ~is_cmp_op(alu_ctrl_q);
`else
  assign wb_write_s = 1'b1;
`endif

  assign cmd_ready    = (state_q == S_IDLE);
  assign done         = (state_q == S_WB);
  assign flags        = flags_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_carry_in = alu_carry_in_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign rd_data      = regs_q[rd_addr];

  // Next-state, register-file and ALU-input computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    regs_d         = regs_q;
    flags_d        = flags_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_carry_in_d = alu_carry_in_q;
    alu_ctrl_d     = alu_ctrl_q;

    case (state_q)
      S_IDLE: begin
        if (ld_en) begin
          regs_d[ld_addr] = ld_data;
        end else begin
          regs_d[ld_addr] = regs_q[ld_addr];
        end
        if (cmd_valid) begin
          // Operands come from regs_d so a same-cycle load is seen first;
          // registering them here makes them valid throughout ISSUE.
          rd_d           = cmd_rd;
          alu_ctrl_d     = cmd_op;
          alu_a_d        = regs_d[cmd_rs1];
          alu_b_d        = regs_d[cmd_rs2];
          alu_carry_in_d = cmd_use_carry & flags_q[3];
          state_d        = S_ISSUE;
        end else begin
          state_d        = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (LAT_M1 == 3'd0) begin
          state_d = S_WB;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          state_d = S_WB;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WB: begin
        if (wb_write_s) begin
          regs_d[rd_q] = alu_result;
        end else begin
          regs_d[rd_q] = regs_q[rd_q];
        end
        flags_d = {alu_flag_carry, alu_flag_zero, alu_flag_overflow, alu_flag_negative};
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 3'd0;
      rd_q           <= '0;
      flags_q        <= 4'd0;
      alu_a_q        <= 8'd0;
      alu_b_q        <= 8'd0;
      alu_carry_in_q <= 1'b0;
      alu_ctrl_q     <= 5'd0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      flags_q        <= flags_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_carry_in_q <= alu_carry_in_d;
      alu_ctrl_q     <= alu_ctrl_d;
      regs_q         <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer. The bench plays the ALU with a
// small behavioural model; "dut" runs with ALU_LATENCY=1, "dut3" with 3.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- latency-1 instance ----------------
  logic       rst, cmd_valid, cmd_use_carry, ld_en;
  logic [4:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2, ld_addr, rd_addr;
  logic [7:0] ld_data;
  logic       cmd_ready, alu_carry_in, done;
  logic [7:0] rd_data, alu_a, alu_b, alu_result;
  logic [4:0] alu_ctrl;
  logic [3:0] flags;
  logic       fc, fz, fv, fn;

  // ---------------- latency-3 instance ----------------
  logic       rst3, cmd_valid3, ld_en3;
  logic [4:0] cmd_op3;
  logic [1:0] cmd_rd3, cmd_rs13, cmd_rs23, ld_addr3, rd_addr3;
  logic [7:0] ld_data3;
  logic       cmd_ready3, alu_carry_in3, done3;
  logic [7:0] rd_data3, alu_a3, alu_b3, alu_result3;
  logic [4:0] alu_ctrl3;
  logic [3:0] flags3;
  logic       fc3, fz3, fv3, fn3;

  // Behavioural ALU: returns {C,Z,V,N,result}.
  function automatic logic [11:0] alu_model(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      5'b00000: begin
        w = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        r = w[7:0];
        c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      5'b00001: begin
        r = a - b;
        c = (a >= b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      5'b00011: begin
        if (b == 8'd0) begin
          r = 8'd0;
          v = 1'b1;
        end else begin
          r = a / b;
        end
      end
      5'b01010: r = {7'd0, (a == b)};
      default:  r = a;
    endcase
    return {c, (r == 8'd0), v, r[7], r};
  endfunction

  assign {fc, fz, fv, fn, alu_result}      = alu_model(alu_ctrl, alu_a, alu_b, alu_carry_in);
  assign {fc3, fz3, fv3, fn3, alu_result3} = alu_model(alu_ctrl3, alu_a3, alu_b3, alu_carry_in3);

  alu_op_sequencer #(.NREGS(4), .REG_AW(2), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_use_carry(cmd_use_carry), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry_in(alu_carry_in), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_flag_carry(fc), .alu_flag_zero(fz), .alu_flag_overflow(fv),
    .alu_flag_negative(fn), .done(done), .flags(flags)
  );

  alu_op_sequencer #(.NREGS(4), .REG_AW(2), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_rd(cmd_rd3), .cmd_rs1(cmd_rs13), .cmd_rs2(cmd_rs23),
    .cmd_use_carry(1'b0), .ld_en(ld_en3), .ld_addr(ld_addr3), .ld_data(ld_data3),
    .rd_addr(rd_addr3), .rd_data(rd_data3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_carry_in(alu_carry_in3), .alu_ctrl(alu_ctrl3), .alu_result(alu_result3),
    .alu_flag_carry(fc3), .alu_flag_zero(fz3), .alu_flag_overflow(fv3),
    .alu_flag_negative(fn3), .done(done3), .flags(flags3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Present a command for one cycle; returns with the DUT in ISSUE.
  task automatic issue(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic uc);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_use_carry = uc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic rdchk3(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr3 = a;
    #1;
    check(tag, rd_data3, exp);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 5'd0; cmd_rd = 2'd0; cmd_rs1 = 2'd0;
    cmd_rs2 = 2'd0; cmd_use_carry = 1'b0; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'd0;
    rd_addr = 2'd0;
    rst3 = 1'b1; cmd_valid3 = 1'b0; cmd_op3 = 5'd0; cmd_rd3 = 2'd0; cmd_rs13 = 2'd0;
    cmd_rs23 = 2'd0; ld_en3 = 1'b0; ld_addr3 = 2'd0; ld_data3 = 8'd0; rd_addr3 = 2'd0;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;
    tick();

    // Reset state
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_flags", flags, 4'h0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_ctrl", alu_ctrl, 5'h00);
    rdchk("rst_r0", 2'd0, 8'h00);

    // ADD FF+01 -> 00, C=1 Z=1
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    issue(5'b00000, 2'd2, 2'd0, 2'd1, 1'b0);
    check("add1_alu_a", alu_a, 8'hFF);
    check("add1_alu_b", alu_b, 8'h01);
    check("add1_cin", alu_carry_in, 0);
    check("add1_ready_busy", cmd_ready, 0);
    check("add1_done_issue", done, 0);
    tick();
    check("add1_done_wb", done, 1);
    check("add1_alu_a_hold", alu_a, 8'hFF);
    tick();
    check("add1_done_clear", done, 0);
    check("add1_ready_t3", cmd_ready, 1);
    check("add1_flags", flags, 4'b1100);
    rdchk("add1_r2", 2'd2, 8'h00);

    // ADD r3+r3+C -> 01
    issue(5'b00000, 2'd3, 2'd3, 2'd3, 1'b1);
    check("add2_cin", alu_carry_in, 1);
    tick(); tick();
    check("add2_flags", flags, 4'b0000);
    rdchk("add2_r3", 2'd3, 8'h01);

    // SUB 05-07 -> FE, N=1, C=0
    load(2'd0, 8'h05);
    load(2'd1, 8'h07);
    issue(5'b00001, 2'd2, 2'd0, 2'd1, 1'b0);
    tick(); tick();
    check("sub_flags", flags, 4'b0001);
    rdchk("sub_r2", 2'd2, 8'hFE);

    // DIV by zero -> 00, V=1 Z=1
    load(2'd1, 8'h00);
    issue(5'b00011, 2'd2, 2'd0, 2'd1, 1'b0);
    tick(); tick();
    check("div_flags", flags, 4'b0110);
    rdchk("div_r2", 2'd2, 8'h00);

    // Load and command in the same IDLE cycle, rs1 = load target
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h55;
    issue(5'b00000, 2'd3, 2'd1, 2'd0, 1'b0);
    ld_en = 1'b0;
    check("ldcmd_alu_a", alu_a, 8'h55);
    check("ldcmd_alu_b", alu_b, 8'h05);
    tick(); tick();
    rdchk("ldcmd_r3", 2'd3, 8'h5A);
    rdchk("ldcmd_r1", 2'd1, 8'h55);

    // CMP_EQ 10 vs 10 into r2 (preloaded 77)
    load(2'd0, 8'h10);
    load(2'd1, 8'h10);
    load(2'd2, 8'h77);
    issue(5'b01010, 2'd2, 2'd0, 2'd1, 1'b0);
    tick();
    check("cmp_done", done, 1);
    tick();
    check("cmp_flags", flags, 4'b0000);
`ifdef ALU_CMP_NOWB_EN
    rdchk("cmp_r2", 2'd2, 8'h77);
`else
    rdchk("cmp_r2", 2'd2, 8'h01);
`endif

    // ---------- latency 3: timing and load-while-busy ----------
    ld_en3 = 1'b1; ld_addr3 = 2'd1; ld_data3 = 8'h33;
    tick();
    ld_en3 = 1'b0;
    cmd_valid3 = 1'b1; cmd_op3 = 5'b00000; cmd_rd3 = 2'd2; cmd_rs13 = 2'd1; cmd_rs23 = 2'd1;
    tick();                                  // t1 ISSUE
    cmd_valid3 = 1'b0;
    check("l3_alu_a", alu_a3, 8'h33);
    tick();                                  // t2 WAIT
    check("l3_done_wait1", done3, 0);
    ld_en3 = 1'b1; ld_addr3 = 2'd1; ld_data3 = 8'hAA;
    tick();                                  // t3 WAIT
    ld_en3 = 1'b0;
    check("l3_done_wait2", done3, 0);
    check("l3_ready_wait", cmd_ready3, 0);
    tick();                                  // t4 WB
    check("l3_done_wb", done3, 1);
    tick();
    check("l3_ready_after", cmd_ready3, 1);
    rdchk3("l3_r2", 2'd2, 8'h66);
    rdchk3("l3_r1_unchanged", 2'd1, 8'h33);

    // ---------- latency 3: reset during WAIT ----------
    cmd_valid3 = 1'b1; cmd_op3 = 5'b00000; cmd_rd3 = 2'd3; cmd_rs13 = 2'd1; cmd_rs23 = 2'd1;
    tick();                                  // ISSUE
    cmd_valid3 = 1'b0;
    tick();                                  // WAIT
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    check("rstw_done", done3, 0);
    tick();
    check("rstw_ready", cmd_ready3, 1);
    for (int i = 0; i < 4; i++) begin
      check("rstw_no_done", done3, 0);
      tick();
    end
    rdchk3("rstw_r3", 2'd3, 8'h00);
    rdchk3("rstw_r2_cleared", 2'd2, 8'h00);
    check("rstw_flags", flags3, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
